// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - two-port round-robin memory access sequencer driving MAR/MDR strobes
module mem_access_ctrl #(
    parameter int TIMEOUT   = 16,
    parameter int ADDR_BITS = 9
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_done,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_done,
    output logic [31:0] rd_data,
    output logic        err,
    output logic        busy,
    output logic        mar_we,
    output logic [31:0] mar_value,
    output logic        mdr_we,
    output logic [31:0] mdr_value,
    output logic        mem_read_en,
    output logic        mem_write_en,
    input  logic        mem_ready,
    input  logic [31:0] mdr_bus
);
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, ADDR, WAIT, DONE} state_t;

    state_t             state, state_nxt;
    logic [31:0]        addr_q;
    logic [31:0]        wdata_q;
    logic               we_q;
    logic               owner_q;
    logic               last_owner_q;
    logic               err_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               grant_if, grant_d;
    logic [31:0]        req_addr;
    logic               oor;
    logic               cnt_last;

    // owner/last_owner encoding: 0 = fetch, 1 = data; grants are gated by clr so none appear in reset
    always_comb begin
        grant_if = 1'b0;
        grant_d  = 1'b0;
        if (clr && state == IDLE) begin
            if (if_req && d_req) begin
                if (last_owner_q) grant_if = 1'b1;
                else              grant_d  = 1'b1;
            end else if (if_req) begin
                grant_if = 1'b1;
            end else if (d_req) begin
                grant_d = 1'b1;
            end
        end
    end

    assign req_addr  = grant_d ? d_addr : if_addr;
    assign oor       = (req_addr >> ADDR_BITS) != 32'd0;
    assign cnt_last  = cnt_q == CNT_W'(TIMEOUT - 1);
    assign if_gnt    = grant_if;
    assign d_gnt     = grant_d;
    assign busy      = state != IDLE;
    assign mar_value = addr_q;
    assign mdr_value = wdata_q;

    always_comb begin
        state_nxt    = state;
        mar_we       = 1'b0;
        mdr_we       = 1'b0;
        mem_read_en  = 1'b0;
        mem_write_en = 1'b0;
        case (state)
            IDLE: begin
                if (grant_if || grant_d) state_nxt = oor ? DONE : ADDR;
            end
            ADDR: begin
                mar_we    = 1'b1;
                mdr_we    = we_q;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (we_q) begin
                    mem_write_en = 1'b1;
                end else begin
                    mem_read_en = 1'b1;
                    mdr_we      = mem_ready;
                end
                if (mem_ready || cnt_last) state_nxt = DONE;
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state        <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            err_q        <= 1'b0;
            cnt_q        <= '0;
            if_done      <= 1'b0;
            d_done       <= 1'b0;
            err          <= 1'b0;
            rd_data      <= '0;
        end else begin
            state   <= state_nxt;
            if_done <= 1'b0;
            d_done  <= 1'b0;
            err     <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_if || grant_d) begin
                        addr_q       <= req_addr;
                        we_q         <= grant_d && d_we;
                        wdata_q      <= grant_d ? d_wdata : 32'd0;
                        owner_q      <= grant_d;
                        last_owner_q <= grant_d;
                        err_q        <= oor;
                    end
                end
                ADDR: cnt_q <= '0;
                WAIT: begin
                    if (!mem_ready) begin
                        if (cnt_last) err_q <= 1'b1;
                        else          cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    if_done <= !owner_q;
                    d_done  <= owner_q;
                    err     <= err_q;
                    rd_data <= (err_q || we_q) ? 32'd0 : mdr_bus;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - self-checking bench for mem_access_ctrl
module tb_mem_access_ctrl;
    localparam int TIMEOUT   = 16;
    localparam int ADDR_BITS = 9;
    localparam int NEVER     = 1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        clr, if_req, if_gnt, if_done, d_req, d_we, d_gnt, d_done, err, busy;
    logic        mar_we, mdr_we, mem_read_en, mem_write_en, mem_ready;
    logic [31:0] if_addr, d_addr, d_wdata, rd_data, mar_value, mdr_value, mdr_bus;

    mem_access_ctrl #(.TIMEOUT(TIMEOUT), .ADDR_BITS(ADDR_BITS)) dut (
        .clk(clk), .clr(clr),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_done(d_done), .rd_data(rd_data), .err(err), .busy(busy),
        .mar_we(mar_we), .mar_value(mar_value), .mdr_we(mdr_we), .mdr_value(mdr_value),
        .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
        .mem_ready(mem_ready), .mdr_bus(mdr_bus)
    );

    typedef struct {
        bit          port;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          preload;
        logic [31:0] mem_data;
        int          k;
        int          exp_lat;
        logic [31:0] exp_rd;
        bit          exp_err;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    // surrounding datapath (MAR, MDR, memory) and the transaction-level reference model
    logic [31:0] env_mem [512];
    logic [31:0] ref_mem [512];
    logic [8:0]  env_mar;
    logic [31:0] env_mdr;
    bit          cap_mar_we, cap_mdr_we, cap_rd, cap_wr, cap_ready;
    logic [31:0] cap_marv, cap_mdrv;
    bit          m_act, m_owner, m_we, m_oor, m_last;
    int          m_g, m_D, m_k, cyc;
    logic [31:0] m_addr, m_wdata, m_rd, m_hold;
    bit          g_if, g_d, rand_mode;
    int          forced_k;
    bit          s_if_gnt, s_d_gnt, s_if_done, s_d_done, s_err;
    logic [31:0] s_rd;
    vec_t        vecs [10];

    task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        if ($urandom_range(0, 7) == 0) a = $urandom | (32'h200 << $urandom_range(0, 22));
        else                           a = 32'($urandom_range(0, 511));
        return a;
    endfunction

    function automatic vec_t mkv(bit port, bit we, logic [31:0] addr, logic [31:0] wdata, bit preload,
                                 logic [31:0] mem_data, int k, int lat, logic [31:0] rd, bit er);
        vec_t v;
        v.port = port; v.we = we; v.addr = addr; v.wdata = wdata; v.preload = preload;
        v.mem_data = mem_data; v.k = k; v.exp_lat = lat; v.exp_rd = rd; v.exp_err = er;
        return v;
    endfunction

    task automatic model_reset();
        m_act = 0; m_last = 1; m_hold = 0; g_if = 0; g_d = 0;
        if_req = 0; d_req = 0;
        cap_mar_we = 0; cap_mdr_we = 0; cap_rd = 0; cap_wr = 0; cap_ready = 0;
    endtask

    // one clock cycle: starts and ends at posedge+1
    task automatic step();
        bit e_ig, e_dg, e_id, e_dd, e_err, e_busy, e_marwe, e_mdrwe, e_rd, e_wr, chk_mar;
        int off;
        e_ig = 0; e_dg = 0; e_id = 0; e_dd = 0; e_err = 0; e_busy = 0;
        e_marwe = 0; e_mdrwe = 0; e_rd = 0; e_wr = 0; chk_mar = 0;
        if (cap_wr && cap_ready) env_mem[env_mar] = env_mdr;
        if (cap_mar_we) env_mar = cap_marv[8:0];
        if (cap_mdr_we) env_mdr = cap_rd ? env_mem[env_mar] : cap_mdrv;
        mdr_bus = env_mdr;
        if (g_if) if_req = 0;
        if (g_d)  d_req  = 0;
        g_if = 0; g_d = 0;
        if (rand_mode) begin
            if (!if_req && $urandom_range(0, 1) == 1) begin if_req = 1; if_addr = rand_addr(); end
            if (!d_req && $urandom_range(0, 1) == 1) begin
                d_req = 1; d_we = 1'($urandom_range(0, 1)); d_addr = rand_addr(); d_wdata = $urandom;
            end
        end
        mem_ready = 1'($urandom_range(0, 1));
        if (m_act) begin
            off = cyc - m_g;
            if (off >= 1 && off < m_D) e_busy = 1;
            if (!m_oor && off == 1) begin e_marwe = 1; e_mdrwe = m_we; chk_mar = 1; end
            if (!m_oor && off >= 2 && off <= m_D - 2) begin
                e_rd = !m_we; e_wr = m_we;
                mem_ready = (off - 2 == m_k);
                e_mdrwe = !m_we && (off - 2 == m_k);
            end
            if (off == m_D) begin
                e_id = !m_owner; e_dd = m_owner; e_err = m_oor || m_k >= TIMEOUT;
                m_hold = m_rd; m_act = 0;
            end
        end
        if (!m_act) begin
            if (if_req && (!d_req || m_last)) g_if = 1;
            else if (d_req)                   g_d  = 1;
            if (g_if || g_d) begin
                m_act = 1; m_g = cyc; m_owner = g_d; m_last = g_d;
                m_we = g_d && d_we; m_addr = g_d ? d_addr : if_addr; m_wdata = d_wdata;
                m_oor = (m_addr >> ADDR_BITS) != 0;
                if (rand_mode) m_k = ($urandom_range(0, 15) == 0) ? NEVER : int'($urandom_range(0, 4));
                else           m_k = forced_k;
                m_D = m_oor ? 2 : (m_k < TIMEOUT ? 4 + m_k : 3 + TIMEOUT);
                m_rd = (m_oor || m_k >= TIMEOUT || m_we) ? 32'd0 : ref_mem[m_addr[8:0]];
                if (!m_oor && m_k < TIMEOUT && m_we) ref_mem[m_addr[8:0]] = m_wdata;
                e_ig = g_if; e_dg = g_d;
            end
        end
        @(negedge clk);
        chk32($sformatf("outputs cyc %0d", cyc),
              {22'd0, if_gnt, d_gnt, if_done, d_done, err, busy, mar_we, mdr_we, mem_read_en, mem_write_en},
              {22'd0, e_ig, e_dg, e_id, e_dd, e_err, e_busy, e_marwe, e_mdrwe, e_rd, e_wr});
        chk32($sformatf("rd_data cyc %0d", cyc), rd_data, m_hold);
        if (chk_mar) begin
            chk32($sformatf("mar_value cyc %0d", cyc), mar_value, m_addr);
            if (m_we) chk32($sformatf("mdr_value cyc %0d", cyc), mdr_value, m_wdata);
        end
        s_if_gnt = if_gnt; s_d_gnt = d_gnt; s_if_done = if_done; s_d_done = d_done;
        s_err = err; s_rd = rd_data;
        cap_mar_we = mar_we; cap_mdr_we = mdr_we; cap_rd = mem_read_en; cap_wr = mem_write_en;
        cap_ready = mem_ready; cap_marv = mar_value; cap_mdrv = mdr_value;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain();
        for (int i = 0; i < 80 && (m_act || if_req || d_req); i++) step();
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int gc, dc, c;
        logic [31:0] rd;
        bit er;
        gc = -100; dc = -1000; rd = 32'hxxxx_xxxx; er = 0;
        if (v.preload) begin env_mem[v.addr[8:0]] = v.mem_data; ref_mem[v.addr[8:0]] = v.mem_data; end
        forced_k = v.k;
        if (v.port) begin d_req = 1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; end
        else        begin if_req = 1; if_addr = v.addr; end
        for (int i = 0; i < 40; i++) begin
            c = cyc;
            step();
            if ((v.port ? s_d_gnt : s_if_gnt) && gc < 0) gc = c;
            if (gc >= 0 && (v.port ? s_d_done : s_if_done)) begin
                dc = c; rd = s_rd; er = s_err;
                break;
            end
        end
        chk32($sformatf("vec %0d latency", idx), 32'(dc - gc), 32'(v.exp_lat));
        chk32($sformatf("vec %0d rd_data", idx), rd, v.exp_rd);
        chk32($sformatf("vec %0d err", idx), {31'd0, er}, {31'd0, v.exp_err});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish before 1ms");
        $fatal(1);
    end

    initial begin
        int order [4];
        int ngr;
        for (int i = 0; i < 512; i++) begin env_mem[i] = $urandom; ref_mem[i] = env_mem[i]; end
        env_mar = 0; env_mdr = 0;
        clr = 0; if_req = 1; d_req = 1; if_addr = 32'h10; d_addr = 32'h11; d_we = 0; d_wdata = 0;
        mem_ready = 0; mdr_bus = 0; cyc = 0; rand_mode = 0; forced_k = 0;
        model_reset();
        if_req = 1; d_req = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk32("reset strobes", {22'd0, if_gnt, d_gnt, if_done, d_done, err, busy, mar_we, mdr_we,
              mem_read_en, mem_write_en}, 32'd0);
        chk32("reset rd_data", rd_data, 32'd0);
        chk32("reset mar_value", mar_value, 32'd0);
        chk32("reset mdr_value", mdr_value, 32'd0);

        @(posedge clk); #1;
        clr = 1;
        for (int i = 0; i < 4; i++) order[i] = 2;
        ngr = 0;
        for (int i = 0; i < 60 && ngr < 4; i++) begin
            step();
            if (i == 0) chk32("first grant after reset", {31'd0, s_if_gnt}, 32'd1);
            if (s_if_gnt)     begin order[ngr] = 0; ngr++; end
            else if (s_d_gnt) begin order[ngr] = 1; ngr++; end
            g_if = 0; g_d = 0; if_req = 1; d_req = 1;
        end
        for (int i = 0; i < 4; i++) chk32($sformatf("arb grant %0d", i), 32'(order[i]), 32'(i % 2));
        if_req = 0; d_req = 0;
        drain();

        vecs[0] = mkv(1, 0, 32'h05,        0,            1, 32'hDEADBEEF, 0,       4,  32'hDEADBEEF, 0);
        vecs[1] = mkv(1, 1, 32'h1FF,       32'h12345678, 0, 0,            3,       7,  32'd0,        0);
        vecs[2] = mkv(1, 0, 32'h1FF,       0,            0, 0,            0,       4,  32'h12345678, 0);
        vecs[3] = mkv(1, 0, 32'h200,       0,            0, 0,            0,       2,  32'd0,        1);
        vecs[4] = mkv(1, 0, 32'h05,        0,            0, 0,            NEVER,   19, 32'd0,        1);
        vecs[5] = mkv(0, 0, 32'h0A,        0,            1, 32'hCAFEF00D, 1,       5,  32'hCAFEF00D, 0);
        vecs[6] = mkv(0, 0, 32'hFFFFFFFF,  0,            0, 0,            0,       2,  32'd0,        1);
        vecs[7] = mkv(1, 0, 32'h0A,        0,            0, 0,            15,      19, 32'hCAFEF00D, 0);
        vecs[8] = mkv(1, 1, 32'h80000005,  32'h55AA55AA, 0, 0,            0,       2,  32'd0,        1);
        vecs[9] = mkv(1, 0, 32'h05,        0,            0, 0,            2,       6,  32'hDEADBEEF, 0);
        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        d_req = 1; d_we = 0; d_addr = 32'h05; forced_k = NEVER;
        repeat (3) step();
        chk32("busy before mid reset", {31'd0, busy}, 32'd1);
        clr = 0;
        #1;
        chk32("strobes after mid reset", {22'd0, if_gnt, d_gnt, if_done, d_done, err, busy, mar_we,
              mdr_we, mem_read_en, mem_write_en}, 32'd0);
        model_reset();
        @(posedge clk); #1;
        clr = 1;
        cyc++;
        repeat (6) step();
        run_vec(vecs[0], 10);

        rand_mode = 1;
        repeat (3000) step();
        rand_mode = 0;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
